// File: rtl/mod_addsub_lanes.sv
// mod_addsub_lanes: multi-lane modular adder/subtractor for the NTT datapath.
// Three register stages (raw result, select flag, final result) advance
// together under a single downstream-driven enable. This lets the block sit
// between the scheduler and memory write-back with no extra stall logic.
module mod_addsub_lanes #(
    parameter int DATA_WIDTH = 12,
    parameter int MODULUS    = 3329,
    parameter int LANES      = 4,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_op,
    input  logic [TAG_WIDTH-1:0]          in_tag,
    input  logic [LANES*DATA_WIDTH-1:0]   in_a,
    input  logic [LANES*DATA_WIDTH-1:0]   in_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_result,
    output logic                          out_op,
    output logic [TAG_WIDTH-1:0]          out_tag,
    output logic                          busy
);

    // One extra bit keeps the carry of an add and the borrow of a subtract.
    localparam int SW = DATA_WIDTH + 1;
    localparam logic [SW-1:0] MOD_EXT = SW'(MODULUS);

    logic adv;

    logic                                 s1ValidQ, s1ValidD;
    logic                                 s1OpQ, s1OpD;
    logic [TAG_WIDTH-1:0]                 s1TagQ, s1TagD;
    logic [LANES-1:0][SW-1:0]             s1SumQ, s1SumD;
    logic [LANES-1:0][DATA_WIDTH-1:0]     s1AltQ, s1AltD;

    logic                                 s2ValidQ, s2ValidD;
    logic                                 s2OpQ, s2OpD;
    logic [TAG_WIDTH-1:0]                 s2TagQ, s2TagD;
    logic [LANES-1:0][DATA_WIDTH-1:0]     s2SumQ, s2SumD;
    logic [LANES-1:0][DATA_WIDTH-1:0]     s2AltQ, s2AltD;
    logic [LANES-1:0]                     s2SelQ, s2SelD;

    logic                                 outValidQ, outValidD;
    logic                                 outOpQ, outOpD;
    logic [TAG_WIDTH-1:0]                 outTagQ, outTagD;
    logic [LANES-1:0][DATA_WIDTH-1:0]     outResultQ, outResultD;

    // The whole pipe moves whenever the output slot is empty or being drained,
    // so bubbles are only squeezed out while nothing is waiting downstream.
    assign adv      = !outValidQ || out_ready;
    assign in_ready = adv;

    assign out_valid  = outValidQ;
    assign out_op     = outOpQ;
    assign out_tag    = outTagQ;
    assign out_result = outResultQ;
    assign busy       = s1ValidQ | s2ValidQ | outValidQ;

    // Stage 1 next state: raw lane sum or difference plus its modulus-corrected twin.
    always_comb begin
        logic [SW-1:0] aW;
        logic [SW-1:0] bW;
        logic [SW-1:0] rawW;
        logic [SW-1:0] altW;
        s1ValidD = s1ValidQ;
        s1OpD    = s1OpQ;
        s1TagD   = s1TagQ;
        s1SumD   = s1SumQ;
        s1AltD   = s1AltQ;
        aW       = '0;
        bW       = '0;
        rawW     = '0;
        altW     = '0;
        if (adv) begin
            s1ValidD = in_valid;
            s1OpD    = in_op;
            s1TagD   = in_tag;
            for (int i = 0; i < LANES; i++) begin
                aW = {1'b0, in_a[i*DATA_WIDTH +: DATA_WIDTH]};
                bW = {1'b0, in_b[i*DATA_WIDTH +: DATA_WIDTH]};
                if (in_op) begin
                    rawW = aW - bW;
                    altW = rawW + MOD_EXT;
                end else begin
                    rawW = aW + bW;
                    altW = rawW - MOD_EXT;
                end
                s1SumD[i] = rawW;
                s1AltD[i] = altW[DATA_WIDTH-1:0];
            end
        end
    end

    // Stage 2 next state: decide per lane whether the corrected value is the answer.
    always_comb begin
        s2ValidD = s2ValidQ;
        s2OpD    = s2OpQ;
        s2TagD   = s2TagQ;
        s2SumD   = s2SumQ;
        s2AltD   = s2AltQ;
        s2SelD   = s2SelQ;
        if (adv) begin
            s2ValidD = s1ValidQ;
            s2OpD    = s1OpQ;
            s2TagD   = s1TagQ;
            s2AltD   = s1AltQ;
            for (int i = 0; i < LANES; i++) begin
                s2SumD[i] = s1SumQ[i][DATA_WIDTH-1:0];
                if (s1OpQ) begin
                    s2SelD[i] = s1SumQ[i][DATA_WIDTH];
                end else begin
                    s2SelD[i] = (s1SumQ[i] >= MOD_EXT);
                end
            end
        end
    end

    // Stage 3 next state: pick the final lane values; held while the consumer stalls.
    always_comb begin
        outValidD  = outValidQ;
        outOpD     = outOpQ;
        outTagD    = outTagQ;
        outResultD = outResultQ;
        if (adv) begin
            outValidD = s2ValidQ;
            outOpD    = s2OpQ;
            outTagD   = s2TagQ;
            for (int i = 0; i < LANES; i++) begin
                outResultD[i] = s2SelQ[i] ? s2AltQ[i] : s2SumQ[i];
            end
        end
    end

    // All pipeline state; reset drops every in-flight transaction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1ValidQ   <= 1'b0;
            s1OpQ      <= 1'b0;
            s1TagQ     <= '0;
            s1SumQ     <= '0;
            s1AltQ     <= '0;
            s2ValidQ   <= 1'b0;
            s2OpQ      <= 1'b0;
            s2TagQ     <= '0;
            s2SumQ     <= '0;
            s2AltQ     <= '0;
            s2SelQ     <= '0;
            outValidQ  <= 1'b0;
            outOpQ     <= 1'b0;
            outTagQ    <= '0;
            outResultQ <= '0;
        end else begin
            s1ValidQ   <= s1ValidD;
            s1OpQ      <= s1OpD;
            s1TagQ     <= s1TagD;
            s1SumQ     <= s1SumD;
            s1AltQ     <= s1AltD;
            s2ValidQ   <= s2ValidD;
            s2OpQ      <= s2OpD;
            s2TagQ     <= s2TagD;
            s2SumQ     <= s2SumD;
            s2AltQ     <= s2AltD;
            s2SelQ     <= s2SelD;
            outValidQ  <= outValidD;
            outOpQ     <= outOpD;
            outTagQ    <= outTagD;
            outResultQ <= outResultD;
        end
    end

endmodule
